// File: rtl/add_sub_comp_pipe.sv
// Two-stage pipelined magnitude comparator (unsigned or two's-complement) with max/min sort.
// Latency 2 cycles; valid/ready with a 2-entry skid, o_ready depends only on registered state and i_ready.
module add_sub_comp_pipe #(
   parameter int SIZE_DATA  = 24,
   parameter int SIZE_GROUP = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [SIZE_DATA-1:0] i_data_a,
   input  logic [SIZE_DATA-1:0] i_data_b,
   input  logic                 i_signed,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_less,
   output logic                 o_equal,
   output logic                 o_greater,
   output logic [SIZE_DATA-1:0] o_data_max,
   output logic [SIZE_DATA-1:0] o_data_min
);
   localparam int NUM_GROUP = SIZE_DATA / SIZE_GROUP;

   logic                 s1_valid;
   logic [NUM_GROUP-1:0] s1_lt;
   logic [NUM_GROUP-1:0] s1_eq;
   logic                 s1_sign_a;
   logic                 s1_sign_b;
   logic                 s1_signed;
   logic [SIZE_DATA-1:0] s1_a;
   logic [SIZE_DATA-1:0] s1_b;

   logic [NUM_GROUP-1:0] grp_lt;
   logic [NUM_GROUP-1:0] grp_eq;
   logic                 less_u;
   logic                 eq_above;
   logic                 nxt_less;
   logic                 nxt_equal;
   logic                 s2_adv;
   logic                 s1_adv;

   assign s2_adv  = ~o_valid | i_ready;
   assign s1_adv  = ~s1_valid | s2_adv;
   assign o_ready = s1_adv;

   always_comb begin
      grp_lt = '0;
      grp_eq = '0;
      for (int g = 0; g < NUM_GROUP; g++) begin
         grp_lt[g] = i_data_a[g*SIZE_GROUP +: SIZE_GROUP] < i_data_b[g*SIZE_GROUP +: SIZE_GROUP];
         grp_eq[g] = i_data_a[g*SIZE_GROUP +: SIZE_GROUP] == i_data_b[g*SIZE_GROUP +: SIZE_GROUP];
      end
   end

   // A lower group only decides the result when every group above it matched.
   always_comb begin
      less_u   = 1'b0;
      eq_above = 1'b1;
      for (int g = NUM_GROUP - 1; g >= 0; g--) begin
         less_u   = less_u | (s1_lt[g] & eq_above);
         eq_above = eq_above & s1_eq[g];
      end
      if (s1_signed && (s1_sign_a != s1_sign_b)) begin
         nxt_less  = s1_sign_a;
         nxt_equal = 1'b0;
      end else begin
         nxt_less  = less_u;
         nxt_equal = eq_above;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1_valid   <= 1'b0;
         s1_lt      <= '0;
         s1_eq      <= '0;
         s1_sign_a  <= 1'b0;
         s1_sign_b  <= 1'b0;
         s1_signed  <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         o_valid    <= 1'b0;
         o_less     <= 1'b0;
         o_equal    <= 1'b0;
         o_greater  <= 1'b0;
         o_data_max <= '0;
         o_data_min <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= i_valid;
            if (i_valid) begin
               s1_lt     <= grp_lt;
               s1_eq     <= grp_eq;
               s1_sign_a <= i_data_a[SIZE_DATA-1];
               s1_sign_b <= i_data_b[SIZE_DATA-1];
               s1_signed <= i_signed;
               s1_a      <= i_data_a;
               s1_b      <= i_data_b;
            end
         end
         if (s2_adv) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
               o_less     <= nxt_less;
               o_equal    <= nxt_equal;
               o_greater  <= ~nxt_less & ~nxt_equal;
               o_data_max <= nxt_less ? s1_b : s1_a;
               o_data_min <= nxt_less ? s1_a : s1_b;
            end
         end
      end
   end
endmodule

// File: tb/tb_add_sub_comp_pipe.sv
// Bench for add_sub_comp_pipe: directed 24/4 sequences plus a randomized 32/8 stream against a reference model.
module tb_add_sub_comp_pipe;
   logic clk;
   logic rst_n;

   logic        v24, ordy24, s24, ovld24, irdy24, lt24, eq24, gt24;
   logic [23:0] a24, b24, max24, min24;
   logic        v32, ordy32, s32, ovld32, irdy32, lt32, eq32, gt32;
   logic [31:0] a32, b32, max32, min32;

   int checks = 0;
   int errors = 0;

   add_sub_comp_pipe #(.SIZE_DATA(24), .SIZE_GROUP(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v24), .o_ready(ordy24),
      .i_data_a(a24), .i_data_b(b24), .i_signed(s24), .o_valid(ovld24),
      .i_ready(irdy24), .o_less(lt24), .o_equal(eq24), .o_greater(gt24),
      .o_data_max(max24), .o_data_min(min24));

   add_sub_comp_pipe #(.SIZE_DATA(32), .SIZE_GROUP(8)) dut32 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v32), .o_ready(ordy32),
      .i_data_a(a32), .i_data_b(b32), .i_signed(s32), .o_valid(ovld32),
      .i_ready(irdy32), .o_less(lt32), .o_equal(eq32), .o_greater(gt32),
      .o_data_max(max32), .o_data_min(min32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: {less, equal, greater, max, min} from plain (signed) arithmetic.
   function automatic logic [50:0] model24(input logic [23:0] a, input logic [23:0] b, input logic s);
      logic lt, eq;
      lt = s ? ($signed(a) < $signed(b)) : (a < b);
      eq = (a == b);
      return {lt, eq, ~lt & ~eq, lt ? b : a, lt ? a : b};
   endfunction

   function automatic logic [66:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
      logic lt, eq;
      lt = s ? ($signed(a) < $signed(b)) : (a < b);
      eq = (a == b);
      return {lt, eq, ~lt & ~eq, lt ? b : a, lt ? a : b};
   endfunction

   task automatic drive24(input logic [23:0] a, input logic [23:0] b, input logic s);
      v24 = 1'b1; a24 = a; b24 = b; s24 = s;
   endtask

   function automatic logic [50:0] out24();
      return {lt24, eq24, gt24, max24, min24};
   endfunction

   logic [23:0] bp_a [4];
   logic [23:0] bp_b [4];
   logic        bp_s [4];
   logic [50:0] snap;
   logic [66:0] exp_q [$];
   logic [66:0] exp32;

   initial begin
      rst_n = 1'b0; v24 = 1'b0; a24 = '0; b24 = '0; s24 = 1'b0; irdy24 = 1'b1;
      v32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; irdy32 = 1'b1;

      // reset state
      repeat (3) @(negedge clk);
      check_val("rst_valid", ovld24, 0);
      check_val("rst_outs", out24(), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("rst_ready", ordy24, 1);

      // simple unsigned less with latency check
      drive24(24'h000010, 24'h000011, 1'b0);
      @(negedge clk); v24 = 1'b0;
      check_val("lat_not_yet", ovld24, 0);
      @(negedge clk);
      check_val("lat_valid", ovld24, 1);
      check_val("t1_less", out24(), {3'b100, 24'h000011, 24'h000010});

      // all-ones vs zero: unsigned then signed back to back
      @(negedge clk);
      drive24(24'hFFFFFF, 24'h000000, 1'b0);
      @(negedge clk); drive24(24'hFFFFFF, 24'h000000, 1'b1);
      @(negedge clk); v24 = 1'b0;
      check_val("ones_u_vld", ovld24, 1);
      check_val("ones_u", out24(), {3'b001, 24'hFFFFFF, 24'h000000});
      @(negedge clk);
      check_val("ones_s_vld", ovld24, 1);
      check_val("ones_s", out24(), {3'b100, 24'h000000, 24'hFFFFFF});

      // equal, group-0 difference, zeros
      @(negedge clk);
      drive24(24'hABCDEF, 24'hABCDEF, 1'b0);
      @(negedge clk); drive24(24'hABCDE0, 24'hABCDE1, 1'b0);
      @(negedge clk); drive24(24'h000000, 24'h000000, 1'b1);
      check_val("eq_abc", out24(), {3'b010, 24'hABCDEF, 24'hABCDEF});
      @(negedge clk); v24 = 1'b0;
      check_val("grp0_less", out24(), {3'b100, 24'hABCDE1, 24'hABCDE0});
      @(negedge clk);
      check_val("zeros_eq", out24(), {3'b010, 24'h000000, 24'h000000});
      @(negedge clk);
      check_val("drain_idle", ovld24, 0);

      // backpressure: 4 compares, i_ready low for 5 cycles
      bp_a[0] = 24'h123456; bp_b[0] = 24'h654321; bp_s[0] = 1'b0;
      bp_a[1] = 24'h800000; bp_b[1] = 24'h7FFFFF; bp_s[1] = 1'b1;
      bp_a[2] = 24'h00FF00; bp_b[2] = 24'h00FF00; bp_s[2] = 1'b0;
      bp_a[3] = 24'hC00001; bp_b[3] = 24'hC00000; bp_s[3] = 1'b1;
      begin
         int sent = 0;
         int recv = 0;
         for (int cyc = 0; cyc < 20; cyc++) begin
            irdy24 = (cyc >= 5);
            if (sent < 4) drive24(bp_a[sent], bp_b[sent], bp_s[sent]);
            else v24 = 1'b0;
            #1;
            if (cyc == 2) snap = out24();
            if (cyc == 3 || cyc == 4) check_val("bp_stable", out24(), snap);
            if (cyc == 4) begin
               check_val("bp_accepts", sent, 2);
               check_val("bp_ready_low", ordy24, 0);
               check_val("bp_held_vld", ovld24, 1);
            end
            if (v24 && ordy24) sent++;
            if (ovld24 && irdy24) begin
               if (recv < 4) check_val("bp_out", out24(), model24(bp_a[recv], bp_b[recv], bp_s[recv]));
               recv++;
            end
            @(negedge clk);
         end
         v24 = 1'b0;
         check_val("bp_sent", sent, 4);
         check_val("bp_recv", recv, 4);
      end

      // reset one cycle after an accept
      drive24(24'h000001, 24'h000002, 1'b0);
      @(negedge clk); v24 = 1'b0; rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      check_val("mid_rst_vld", ovld24, 0);
      check_val("mid_rst_outs", out24(), 0);
      check_val("mid_rst_rdy", ordy24, 1);
      begin
         int seen = 0;
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ovld24) seen++;
         end
         check_val("mid_rst_flush", seen, 0);
      end

      // randomized 32/8 stream with random backpressure
      begin
         int gen = 0;
         int recv = 0;
         bit have = 0;
         for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
            @(negedge clk);
            if (!have && gen < 1000) begin
               int mode;
               mode = $urandom_range(0, 3);
               a32 = $urandom;
               case (mode)
                  0: b32 = $urandom;
                  1: b32 = a32;
                  2: b32 = a32 ^ (32'h1 << $urandom_range(0, 31));
                  default: b32 = {a32[31:16], 16'($urandom)};
               endcase
               s32 = $urandom_range(0, 1);
               have = 1;
               gen++;
            end
            v32 = have && ($urandom_range(0, 3) != 0);
            irdy32 = ($urandom_range(0, 3) != 0);
            #1;
            if (v32 && ordy32) begin
               exp_q.push_back(model32(a32, b32, s32));
               have = 0;
            end
            if (ovld32 && irdy32) begin
               if (exp_q.size() == 0) check_val("rand_extra", 1, 0);
               else begin
                  exp32 = exp_q.pop_front();
                  check_val("rand_vec", {lt32, eq32, gt32, max32, min32}, exp32);
               end
               recv++;
            end
         end
         v32 = 1'b0;
         check_val("rand_count", recv, 1000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
